serial_adder_subtractor: RTL

- Parametrised, multi-cycle successor to the ripple add/sub block.
- Adds or subtracts two WIDTH-bit operands one DIGIT-bit slice per clock, LSB first. Ripple logic stays DIGIT bits deep regardless of WIDTH.
- Adds a start/busy/done handshake, a full status-flag set (carry, signed overflow, zero, negative) and optional signed saturation.
- Used wherever wide arithmetic must close timing at small area.

---
 rtl/serial_adder_subtractor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor. It processes DIGIT bits per clock, LSB first,
// and provides a start/busy/done handshake, status flags and optional signed saturation.
module serial_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_RUN   = 2'd1;
    localparam logic [1:0]       S_DONE  = 2'd2;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] a,
                                                 input logic [DIGIT-1:0] b,
                                                 input logic             cin);
        slice_add = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sub_q, sub_d, sat_q, sat_d, cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

    logic [DIGIT-1:0] a_sl_s, bx_sl_s;
    logic [DIGIT:0]   sum_s;
    logic [WIDTH-1:0] raw_s, final_s, a_nx_s, b_nx_s;
    logic             ovf_s, accept_s, last_s;

    assign a_sl_s   = a_q[DIGIT-1:0];
    assign bx_sl_s  = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};
    assign sum_s    = slice_add(a_sl_s, bx_sl_s, cy_q);
    // carry into the MSB is recovered as a ^ b ^ sum at that bit position
    assign ovf_s    = a_sl_s[DIGIT-1] ^ bx_sl_s[DIGIT-1] ^ sum_s[DIGIT-1] ^ sum_s[DIGIT];
    assign final_s  = (sat_q && ovf_s) ? (a_sl_s[DIGIT-1] ? SAT_NEG : SAT_POS) : raw_s;
    assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_s   = (cnt_q == LAST);

    generate
        if (DIGIT < WIDTH) begin : g_multi
            logic [WIDTH-DIGIT-1:0] acc_q;

            // Partial-result shift register: completed slices enter at the top and move down.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= {(WIDTH-DIGIT){1'b0}};
                end else if (accept_s) begin
                    acc_q <= {(WIDTH-DIGIT){1'b0}};
                end else if (state_q == S_RUN) begin
                    acc_q <= raw_s[WIDTH-1:DIGIT];
                end else begin
                    acc_q <= acc_q;
                end
            end

            assign raw_s  = {sum_s[DIGIT-1:0], acc_q};
            assign a_nx_s = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
            assign b_nx_s = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign raw_s  = sum_s[DIGIT-1:0];
            assign a_nx_s = {WIDTH{1'b0}};
            assign b_nx_s = {WIDTH{1'b0}};
        end
    endgenerate

    // Next-state logic for the IDLE/RUN/DONE sequencer, the operand shifters and the outputs.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        sat_d    = sat_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    sat_d   = sat;
                    cy_d    = sub;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_nx_s;
                b_d   = b_nx_s;
                cy_d  = sum_s[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = final_s;
                    cout_d   = sum_s[DIGIT];
                    ovf_d    = ovf_s;
                    zero_d   = (final_s == {WIDTH{1'b0}});
                    neg_d    = final_s[WIDTH-1];
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            sub_q    <= 1'b0;
            sat_q    <= 1'b0;
            cy_q     <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            sat_q    <= sat_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule
